lq_agen_csel_stage: RTL and testbench

//  EX1->EX2 carry-select and stage latch for the ERAT-bound effective-address bits.
//  - Consumes per-nibble conditional sums (sum_0 = carry-in 0, sum_1 = carry-in 1) from the agen byte macros.
//  - Selects each group with its late-arriving group carry from the low-order carry tree.
//  - Registers the resulting EA slice and presents it to the ERAT with a valid/ready handshake.
//  - A 2-entry skid buffer absorbs one cycle of ERAT backpressure. Per-thread flush kills entries in flight.

---
 rtl/lq_agen_pkg.sv | 12 +
 rtl/lq_agen_csel_mux.sv | 22 ++
 rtl/lq_agen_csel_stage.sv | 130 +++++++++++++
 tb/tb_lq_agen_csel_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lq_agen_pkg.sv
// lq_agen_pkg: shared constants for the load-queue agen EX1->EX2 slice.
//   CSEL_*  : skid-stage occupancy encoding, {skid_vld, main_vld}
//   GRP_W   : width of one conditional-sum group (nibble)
package lq_agen_pkg;

  localparam logic [1:0] CSEL_EMPTY = 2'b00;
  localparam logic [1:0] CSEL_ONE   = 2'b01;
  localparam logic [1:0] CSEL_TWO   = 2'b11;

  localparam int GRP_W = 4;

endpackage

// File: rtl/lq_agen_csel_mux.sv
// lq_agen_csel_mux: per-group 2:1 carry-select of conditional sums.
//   i_sum_0 : sums assuming carry-in 0, [0:GRP_W*NGRP-1], bit 0 = MSB
//   i_sum_1 : sums assuming carry-in 1
//   i_cin   : late group carries, i_cin[g] picks bits [GRP_W*g +: GRP_W]
//   o_sel   : selected EA slice
module lq_agen_csel_mux
  import lq_agen_pkg::*;
#(
  parameter int NGRP = 4
) (
  input  logic [0:GRP_W*NGRP-1] i_sum_0,
  input  logic [0:GRP_W*NGRP-1] i_sum_1,
  input  logic [0:NGRP-1]       i_cin,
  output logic [0:GRP_W*NGRP-1] o_sel
);

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign o_sel[GRP_W*g +: GRP_W] = i_cin[g] ? i_sum_1[GRP_W*g +: GRP_W]
                                              : i_sum_0[GRP_W*g +: GRP_W];
  end

endmodule

// File: rtl/lq_agen_csel_stage.sv
// lq_agen_csel_stage: EX1->EX2 carry-select and stage latch feeding the ERAT.
//   nclk, rst_b        : clock (rising), async active-low reset of valid bits
//   ex1_vld / ex1_rdy  : EX1 request handshake; ex1_rdy = !skid_vld (registered)
//   ex1_sum_0/_1, cin  : conditional sums and group carries, selected here
//   ex1_tid, flush     : request thread and per-thread flush lines
//   ex2_vld / ex2_rdy  : ERAT handshake; ex2_ea / ex2_tid valid with ex2_vld
// Main entry drives ex2_*; a skid entry absorbs one cycle of backpressure.
module lq_agen_csel_stage
  import lq_agen_pkg::*;
#(
  parameter int NGRP    = 4,
  parameter int TID_W   = 2,
  parameter int THREADS = 2
) (
  input  logic                   nclk,
  input  logic                   rst_b,
  input  logic                   ex1_vld,
  output logic                   ex1_rdy,
  input  logic [0:GRP_W*NGRP-1]  ex1_sum_0,
  input  logic [0:GRP_W*NGRP-1]  ex1_sum_1,
  input  logic [0:NGRP-1]        ex1_cin,
  input  logic [TID_W-1:0]       ex1_tid,
  input  logic [THREADS-1:0]     flush,
  output logic                   ex2_vld,
  input  logic                   ex2_rdy,
  output logic [0:GRP_W*NGRP-1]  ex2_ea,
  output logic [TID_W-1:0]       ex2_tid
);

  // tid values beyond THREADS have no flush line and are never flushed
  function automatic logic tid_fl(input logic [TID_W-1:0] t,
                                  input logic [THREADS-1:0] f);
    logic r;
    r = 1'b0;
    for (int k = 0; k < THREADS; k++)
      if (t == TID_W'(k)) r = f[k];
    return r;
  endfunction

  logic [0:GRP_W*NGRP-1] w_sel;

  lq_agen_csel_mux #(.NGRP(NGRP)) u_mux (
    .i_sum_0 (ex1_sum_0),
    .i_sum_1 (ex1_sum_1),
    .i_cin   (ex1_cin),
    .o_sel   (w_sel)
  );

  logic                  r_main_vld, r_skid_vld;
  logic [0:GRP_W*NGRP-1] r_main_ea,  r_skid_ea;
  logic [TID_W-1:0]      r_main_tid, r_skid_tid;

  logic [1:0] w_state;
  logic       w_pop, w_acc, w_main_keep, w_skid_keep;
  logic       w_main_vld_nxt, w_skid_vld_nxt;
  logic       w_ld_main, w_ld_skid, w_promote;

  assign w_state = {r_skid_vld, r_main_vld};
  assign ex1_rdy = ~r_skid_vld;
  assign ex2_vld = r_main_vld;
  assign ex2_ea  = r_main_ea;
  assign ex2_tid = r_main_tid;

  assign w_pop       = r_main_vld & ex2_rdy;
  assign w_acc       = ex1_vld & ex1_rdy & ~tid_fl(ex1_tid, flush);
  // a pop wins over a flush of the same main entry
  assign w_main_keep = r_main_vld & ~w_pop & ~tid_fl(r_main_tid, flush);
  assign w_skid_keep = r_skid_vld & ~tid_fl(r_skid_tid, flush);

  always_comb begin
    w_main_vld_nxt = 1'b0;
    w_skid_vld_nxt = 1'b0;
    w_ld_main      = 1'b0;
    w_ld_skid      = 1'b0;
    w_promote      = 1'b0;
    case (w_state)
      CSEL_EMPTY: begin
        w_main_vld_nxt = w_acc;
        w_ld_main      = w_acc;
      end
      CSEL_ONE: begin
        if (w_main_keep) begin
          w_main_vld_nxt = 1'b1;
          w_skid_vld_nxt = w_acc;
          w_ld_skid      = w_acc;
        end else begin
          w_main_vld_nxt = w_acc;
          w_ld_main      = w_acc;
        end
      end
      CSEL_TWO: begin
        // ex1_rdy is low here, so nothing new enters
        if (w_main_keep) begin
          w_main_vld_nxt = 1'b1;
          w_skid_vld_nxt = w_skid_keep;
        end else begin
          w_main_vld_nxt = w_skid_keep;
          w_promote      = w_skid_keep;
        end
      end
      default: ;  // skid-only is unreachable; fall back to empty
    endcase
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
    end
  end

  // payload latches carry no reset; only meaningful under their valid bit
  always_ff @(posedge nclk) begin
    if (w_ld_main) begin
      r_main_ea  <= w_sel;
      r_main_tid <= ex1_tid;
    end else if (w_promote) begin
      r_main_ea  <= r_skid_ea;
      r_main_tid <= r_skid_tid;
    end
    if (w_ld_skid) begin
      r_skid_ea  <= w_sel;
      r_skid_tid <= ex1_tid;
    end
  end

endmodule

// File: tb/tb_lq_agen_csel_stage.sv
module tb_lq_agen_csel_stage;

  logic        nclk = 1'b0;
  logic        rst_b;
  logic        ex1_vld;
  logic        ex1_rdy;
  logic [15:0] ex1_sum_0, ex1_sum_1;
  logic [0:3]  ex1_cin;
  logic [1:0]  ex1_tid;
  logic [1:0]  flush;
  logic        ex2_vld;
  logic        ex2_rdy;
  logic [15:0] ex2_ea;
  logic [1:0]  ex2_tid;

  int checks   = 0;
  int failures = 0;

  always #5 nclk = ~nclk;

  lq_agen_csel_stage #(.NGRP(4), .TID_W(2), .THREADS(2)) dut (
    .nclk(nclk), .rst_b(rst_b), .ex1_vld(ex1_vld), .ex1_rdy(ex1_rdy),
    .ex1_sum_0(ex1_sum_0), .ex1_sum_1(ex1_sum_1), .ex1_cin(ex1_cin),
    .ex1_tid(ex1_tid), .flush(flush), .ex2_vld(ex2_vld), .ex2_rdy(ex2_rdy),
    .ex2_ea(ex2_ea), .ex2_tid(ex2_tid)
  );

  typedef struct {
    logic [15:0] ea;
    logic [1:0]  tid;
  } ent_t;

  // model: FIFO of at most two entries in the order the ERAT will see them
  ent_t mq[$];
  ent_t nq[$];
  ent_t kq[$];

  function automatic logic [15:0] csel(input logic [15:0] s0, input logic [15:0] s1,
                                       input logic [0:3] c);
    logic [15:0] m;
    m = 16'h0;
    for (int g = 0; g < 4; g++)
      if (c[g]) m = m | (16'hF000 >> (4 * g));
    return (s1 & m) | (s0 & ~m);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_next();
    int n;
    ent_t e;
    nq = mq;
    kq = {};
    n = mq.size();
    if (rst_b) begin
      if (n > 0 && ex2_rdy) void'(nq.pop_front());
      foreach (nq[i]) if (!flush[nq[i].tid[0]]) kq.push_back(nq[i]);
      if (ex1_vld && n < 2 && !flush[ex1_tid[0]]) begin
        e.ea  = csel(ex1_sum_0, ex1_sum_1, ex1_cin);
        e.tid = ex1_tid;
        kq.push_back(e);
      end
    end
    nq = kq;
  endtask

  task automatic step();
    model_next();
    @(posedge nclk);
    mq = nq;
    #1;
  endtask

  task automatic drive(input logic [15:0] s0, input logic [15:0] s1,
                       input logic [0:3] c, input logic [1:0] t);
    ex1_vld   = 1'b1;
    ex1_sum_0 = s0;
    ex1_sum_1 = s1;
    ex1_cin   = c;
    ex1_tid   = t;
  endtask

  // continuous comparison against the model on the falling edge
  initial begin
    forever begin
      @(negedge nclk);
      chk("m_ex2_vld", {31'd0, ex2_vld}, {31'd0, mq.size() > 0});
      chk("m_ex1_rdy", {31'd0, ex1_rdy}, {31'd0, mq.size() < 2});
      if (ex2_vld && mq.size() > 0) begin
        chk("m_ex2_ea",  {16'd0, ex2_ea},  {16'd0, mq[0].ea});
        chk("m_ex2_tid", {30'd0, ex2_tid}, {30'd0, mq[0].tid});
      end
    end
  end

  initial begin
    rst_b = 1'b0; ex1_vld = 1'b0; ex1_sum_0 = '0; ex1_sum_1 = '0;
    ex1_cin = '0; ex1_tid = '0; flush = '0; ex2_rdy = 1'b1;
    repeat (3) step();
    chk("rst_vld", {31'd0, ex2_vld}, 32'd0);
    chk("rst_rdy", {31'd0, ex1_rdy}, 32'd1);
    rst_b = 1'b1;

    // 1: single request, no backpressure
    chk("csel_model", {16'd0, csel(16'h1234, 16'h2345, 4'b0101)}, 32'h1335);
    drive(16'h1234, 16'h2345, 4'b0101, 2'd1);
    step();
    ex1_vld = 1'b0;
    chk("c1_vld", {31'd0, ex2_vld}, 32'd1);
    chk("c1_ea",  {16'd0, ex2_ea},  32'h1335);
    chk("c1_tid", {30'd0, ex2_tid}, 32'd1);
    step();
    chk("c1_vld2", {31'd0, ex2_vld}, 32'd0);

    // 2: backpressure fills the skid
    ex2_rdy = 1'b0;
    drive(16'hAAAA, 16'hAAAA, 4'b0000, 2'd0);
    step();
    drive(16'hBBBB, 16'hBBBB, 4'b1111, 2'd1);
    step();
    ex1_vld = 1'b0;
    chk("c2_rdy0", {31'd0, ex1_rdy}, 32'd0);
    chk("c2_eaA",  {16'd0, ex2_ea},  32'hAAAA);
    ex2_rdy = 1'b1;
    step();
    chk("c2_vldB", {31'd0, ex2_vld}, 32'd1);
    chk("c2_eaB",  {16'd0, ex2_ea},  32'hBBBB);
    chk("c2_rdy1", {31'd0, ex1_rdy}, 32'd1);
    step();
    chk("c2_empty", {31'd0, ex2_vld}, 32'd0);

    // 3: streaming
    for (int i = 0; i < 8; i++) begin
      drive(16'(i), 16'hFFFF, 4'b0000, 2'(i % 2));
      step();
      chk("c3_rdy", {31'd0, ex1_rdy}, 32'd1);
      chk("c3_ea",  {16'd0, ex2_ea},  i);
    end
    ex1_vld = 1'b0;
    step();

    // 4: flush in state TWO, main thread only
    ex2_rdy = 1'b0;
    drive(16'h4444, 16'h0000, 4'b0000, 2'd0);
    step();
    drive(16'h0000, 16'h5555, 4'b1111, 2'd1);
    step();
    ex1_vld = 1'b0;
    flush = 2'b01;
    step();
    flush = 2'b00;
    chk("c4_vld", {31'd0, ex2_vld}, 32'd1);
    chk("c4_ea",  {16'd0, ex2_ea},  32'h5555);
    chk("c4_tid", {30'd0, ex2_tid}, 32'd1);
    chk("c4_rdy", {31'd0, ex1_rdy}, 32'd1);
    ex2_rdy = 1'b1;
    step();
    ex2_rdy = 1'b0;
    // both threads flushed
    drive(16'h4444, 16'h0000, 4'b0000, 2'd0);
    step();
    drive(16'h0000, 16'h5555, 4'b1111, 2'd1);
    step();
    ex1_vld = 1'b0;
    flush = 2'b11;
    step();
    flush = 2'b00;
    chk("c4b_vld", {31'd0, ex2_vld}, 32'd0);
    chk("c4b_rdy", {31'd0, ex1_rdy}, 32'd1);

    // 5: EX1 request of a flushed thread is dropped
    ex2_rdy = 1'b1;
    drive(16'h6666, 16'h6666, 4'b0000, 2'd0);
    flush = 2'b01;
    step();
    ex1_vld = 1'b0;
    flush = 2'b00;
    chk("c5_vld", {31'd0, ex2_vld}, 32'd0);
    step();
    chk("c5_vld2", {31'd0, ex2_vld}, 32'd0);

    // 6: async reset from state TWO
    ex2_rdy = 1'b0;
    drive(16'h7777, 16'h7777, 4'b0000, 2'd0);
    step();
    drive(16'h8888, 16'h8888, 4'b0000, 2'd1);
    step();
    ex1_vld = 1'b0;
    chk("c6_pre_rdy", {31'd0, ex1_rdy}, 32'd0);
    #2;
    rst_b = 1'b0;
    mq.delete();
    #1;
    chk("c6_vld", {31'd0, ex2_vld}, 32'd0);
    chk("c6_rdy", {31'd0, ex1_rdy}, 32'd1);
    step();
    rst_b = 1'b1;
    ex2_rdy = 1'b1;
    drive(16'h1234, 16'h2345, 4'b0101, 2'd1);
    step();
    ex1_vld = 1'b0;
    chk("c6_vld1", {31'd0, ex2_vld}, 32'd1);
    chk("c6_ea",   {16'd0, ex2_ea},  32'h1335);
    chk("c6_tid",  {30'd0, ex2_tid}, 32'd1);
    step();
    chk("c6_vld2", {31'd0, ex2_vld}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
